trap_ctrl: RTL and testbench

//  Machine-mode trap sequencer for cpu_top. Arbitrates exception, interrupt and mret requests.

---
 rtl/trap_pkg.sv | 42 ++++
 rtl/trap_prio_sel.sv | 27 ++
 rtl/trap_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses,
// FSM state encoding, request kinds and mtvec modes.
package trap_pkg;

   localparam logic [11:0] addr_mstatus = 12'h300;
   localparam logic [11:0] addr_mepc    = 12'h341;
   localparam logic [11:0] addr_mcause  = 12'h342;
   localparam logic [11:0] addr_mtval   = 12'h343;

   localparam logic [2:0] st_idle     = 3'd0;
   localparam logic [2:0] st_w_epc    = 3'd1;
   localparam logic [2:0] st_w_cause  = 3'd2;
   localparam logic [2:0] st_w_tval   = 3'd3;
   localparam logic [2:0] st_w_status = 3'd4;
   localparam logic [2:0] st_m_status = 3'd5;
   localparam logic [2:0] st_redirect = 3'd6;

   // one-hot grant vector {exc, irq, mret}
   localparam logic [2:0] gnt_none = 3'b000;
   localparam logic [2:0] gnt_exc  = 3'b100;
   localparam logic [2:0] gnt_irq  = 3'b010;
   localparam logic [2:0] gnt_mret = 3'b001;

   localparam logic [1:0] mtvec_direct   = 2'b00;
   localparam logic [1:0] mtvec_vectored = 2'b01;

   localparam logic [3:0] cause_ecall_m = 4'd11;
   localparam logic [3:0] cause_mtimer  = 4'd7;

   typedef enum logic [1:0] {
      kind_exc  = 2'd0,
      kind_irq  = 2'd1,
      kind_mret = 2'd2
   } trap_kind_e;

   // states of the four-write trap path, excluding REDIRECT
   function automatic logic is_trap_write(input logic [2:0] s);
      return (s == st_w_epc) || (s == st_w_cause) ||
             (s == st_w_tval) || (s == st_w_status);
   endfunction

endpackage

// File: rtl/trap_prio_sel.sv
// Request qualification and fixed-priority arbitration: exception beats
// enabled interrupt beats mret. Output is a one-hot {exc, irq, mret} grant.
module trap_prio_sel
   import trap_pkg::*;
(
   input  logic       exc_valid,
   input  logic       irq_pending,
   input  logic       irq_enable,
   input  logic       mret_valid,
   output logic [2:0] grant
);

   logic irq_qual;

   assign irq_qual = irq_pending & irq_enable;

   always_comb begin
      grant = gnt_none;
      if (exc_valid)
         grant = gnt_exc;
      else if (irq_qual)
         grant = gnt_irq;
      else if (mret_valid)
         grant = gnt_mret;
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: captures one request in IDLE, writes the trap
// CSRs one per accepted cycle, then flushes and redirects the PC.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MIE_BIT  = 3,
   parameter int MPIE_BIT = 7,
   parameter int MPP_LSB  = 11
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exc_valid,
   input  logic [3:0]      exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            irq_pending,
   input  logic [3:0]      irq_cause,
   input  logic [XLEN-1:0] irq_pc,
   input  logic            mret_valid,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   input  logic [XLEN-1:0] mstatus,
   output logic            csr_we,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   input  logic            csr_ready,
   output logic            exc_ack,
   output logic            irq_ack,
   output logic            mret_ack,
   output logic            stall,
   output logic            flush,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            exc_en
);

   logic [2:0]      state, state_nxt;
   logic [2:0]      grant;
   logic            capture;
   trap_kind_e      kind;
   logic [3:0]      cause_q;
   logic [XLEN-1:0] pc_q, tval_q, status_q, epc_q;
   logic [XLEN-1:0] base, target;

   function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] r;
      r                = s;
      r[MPIE_BIT]      = s[MIE_BIT];
      r[MIE_BIT]       = 1'b0;
      r[MPP_LSB +: 2]  = 2'b11;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] r;
      r           = s;
      r[MIE_BIT]  = s[MPIE_BIT];
      r[MPIE_BIT] = 1'b1;
      return r;
   endfunction

   trap_prio_sel u_prio (
      .exc_valid   (exc_valid),
      .irq_pending (irq_pending),
      .irq_enable  (mstatus[MIE_BIT]),
      .mret_valid  (mret_valid),
      .grant       (grant)
   );

   assign capture = (state == st_idle) && (grant != gnt_none);

   always_comb begin
      state_nxt = state;
      case (state)
         st_idle: begin
            if (grant == gnt_exc || grant == gnt_irq)
               state_nxt = st_w_epc;
            else if (grant == gnt_mret)
               state_nxt = st_m_status;
         end
         st_w_epc:    if (csr_ready) state_nxt = st_w_cause;
         st_w_cause:  if (csr_ready) state_nxt = st_w_tval;
         st_w_tval:   if (csr_ready) state_nxt = st_w_status;
         st_w_status: if (csr_ready) state_nxt = st_redirect;
         st_m_status: if (csr_ready) state_nxt = st_redirect;
         st_redirect: state_nxt = st_idle;
         default:     state_nxt = st_idle;
      endcase
   end

   // the request context is frozen at capture so the requester may change
   // its inputs once it has seen the ack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= st_idle;
         kind     <= kind_exc;
         cause_q  <= '0;
         pc_q     <= '0;
         tval_q   <= '0;
         status_q <= '0;
         epc_q    <= '0;
         exc_ack  <= 1'b0;
         irq_ack  <= 1'b0;
         mret_ack <= 1'b0;
      end else begin
         state    <= state_nxt;
         exc_ack  <= 1'b0;
         irq_ack  <= 1'b0;
         mret_ack <= 1'b0;
         if (capture) begin
            if (grant == gnt_exc)
               kind <= kind_exc;
            else if (grant == gnt_irq)
               kind <= kind_irq;
            else
               kind <= kind_mret;
            cause_q  <= (grant == gnt_exc) ? exc_cause : irq_cause;
            pc_q     <= (grant == gnt_exc) ? exc_pc    : irq_pc;
            tval_q   <= (grant == gnt_exc) ? exc_tval  : '0;
            status_q <= mstatus;
            epc_q    <= mepc;
            exc_ack  <= grant[2];
            irq_ack  <= grant[1];
            mret_ack <= grant[0];
         end
      end
   end

   always_comb begin
      csr_we    = 1'b0;
      csr_addr  = '0;
      csr_wdata = '0;
      case (state)
         st_w_epc: begin
            csr_we    = 1'b1;
            csr_addr  = addr_mepc;
            csr_wdata = pc_q;
         end
         st_w_cause: begin
            csr_we    = 1'b1;
            csr_addr  = addr_mcause;
            csr_wdata = {kind == kind_irq, {(XLEN-5){1'b0}}, cause_q};
         end
         st_w_tval: begin
            csr_we    = 1'b1;
            csr_addr  = addr_mtval;
            csr_wdata = tval_q;
         end
         st_w_status: begin
            csr_we    = 1'b1;
            csr_addr  = addr_mstatus;
            csr_wdata = trap_status(status_q);
         end
         st_m_status: begin
            csr_we    = 1'b1;
            csr_addr  = addr_mstatus;
            csr_wdata = mret_status(status_q);
         end
         default: ;
      endcase
   end

   // vectored mode only applies to interrupts; exceptions always use the base
   assign base = {mtvec[XLEN-1:2], 2'b00};

   always_comb begin
      target = base;
      if (kind == kind_mret)
         target = epc_q;
      else if (kind == kind_irq && mtvec[1:0] == mtvec_vectored)
         target = base + {{(XLEN-6){1'b0}}, cause_q, 2'b00};
   end

   assign redirect_valid = (state == st_redirect);
   assign flush          = redirect_valid;
   assign redirect_pc    = redirect_valid ? target : '0;
   assign stall          = (state != st_idle);
   assign exc_en         = is_trap_write(state) || (redirect_valid && kind != kind_mret);

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized bench for trap_ctrl: a transaction-level model predicts the
// ack order, CSR write list and redirect target of every request set.
module tb_trap_ctrl;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            exc_valid, irq_pending, mret_valid, csr_ready;
   logic [3:0]      exc_cause, irq_cause;
   logic [XLEN-1:0] exc_pc, exc_tval, irq_pc, mtvec, mepc, mstatus;
   logic            csr_we, exc_ack, irq_ack, mret_ack, stall, flush, redirect_valid, exc_en;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata, redirect_pc;

   always #5 clk = ~clk;

   trap_ctrl #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .irq_pending(irq_pending), .irq_cause(irq_cause), .irq_pc(irq_pc),
      .mret_valid(mret_valid), .mtvec(mtvec), .mepc(mepc), .mstatus(mstatus),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_ready(csr_ready),
      .exc_ack(exc_ack), .irq_ack(irq_ack), .mret_ack(mret_ack),
      .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .exc_en(exc_en)
   );

   int total = 0;
   int bad   = 0;
   logic [43:0] exp_wr[$];
   logic [31:0] exp_rd[$];
   logic [2:0]  exp_ack[$];
   int          ack_cyc[$];
   int          cyc, first_redir, en_cnt, ready_mode;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] trap_st(input logic [31:0] m);
      logic [31:0] r;
      r = m & ~32'h0000_0088;
      if (m[3]) r = r | 32'h0000_0080;
      return r | 32'h0000_1800;
   endfunction

   function automatic logic [31:0] mret_st(input logic [31:0] m);
      logic [31:0] r;
      r = m & ~32'h0000_0008;
      if (m[7]) r = r | 32'h0000_0008;
      return r | 32'h0000_0080;
   endfunction

   task automatic model_push(input logic [2:0] k);
      logic [31:0] base;
      base = mtvec & ~32'h3;
      case (k)
         3'b100: begin
            exp_wr.push_back({12'h341, exc_pc});
            exp_wr.push_back({12'h342, 28'd0, exc_cause});
            exp_wr.push_back({12'h343, exc_tval});
            exp_wr.push_back({12'h300, trap_st(mstatus)});
            exp_rd.push_back(base);
         end
         3'b010: begin
            exp_wr.push_back({12'h341, irq_pc});
            exp_wr.push_back({12'h342, 32'h8000_0000 | 32'(irq_cause)});
            exp_wr.push_back({12'h343, 32'd0});
            exp_wr.push_back({12'h300, trap_st(mstatus)});
            exp_rd.push_back((mtvec[1:0] == 2'b01) ? base + 32'(irq_cause) * 4 : base);
         end
         default: begin
            exp_wr.push_back({12'h300, mret_st(mstatus)});
            exp_rd.push_back(mepc);
         end
      endcase
      exp_ack.push_back(k);
   endtask

   task automatic step();
      logic [43:0] w;
      logic [2:0]  k;
      @(posedge clk); #1;
      cyc++;
      if (exc_ack || irq_ack || mret_ack) begin
         ack_cyc.push_back(cyc);
         k = 3'b000;
         if (exp_ack.size() != 0) k = exp_ack.pop_front();
         chk("ack_kind", {exc_ack, irq_ack, mret_ack}, k);
         if (exc_ack)  exc_valid   = 1'b0;
         if (irq_ack)  irq_pending = 1'b0;
         if (mret_ack) mret_valid  = 1'b0;
      end
      case (ready_mode)
         0:       csr_ready = 1'b1;
         1:       csr_ready = ($urandom_range(0, 3) != 0);
         default: csr_ready = !(cyc >= 2 && cyc <= 4);
      endcase
      if (csr_we) begin
         if (exp_wr.size() == 0) chk("wr_extra", csr_we, 1'b0);
         else begin
            w = exp_wr[0];
            chk("wr_addr", csr_addr, w[43:32]);
            chk("wr_data", csr_wdata, w[31:0]);
            if (csr_ready) void'(exp_wr.pop_front());
         end
      end
      if (redirect_valid) begin
         chk("flush", flush, 1'b1);
         if (first_redir < 0) first_redir = cyc;
         if (exp_rd.size() == 0) chk("redir_extra", redirect_valid, 1'b0);
         else chk("redir_pc", redirect_pc, exp_rd.pop_front());
      end else if (flush) chk("flush_alone", flush, 1'b0);
      if (exc_en) en_cnt++;
   endtask

   task automatic round(input logic e, input logic i, input logic m, input int mode, input int max_cyc);
      ready_mode = mode;
      if (e) model_push(3'b100);
      if (i && mstatus[3]) model_push(3'b010);
      if (m) model_push(3'b001);
      exc_valid = e; irq_pending = i; mret_valid = m;
      cyc = 0; first_redir = -1; en_cnt = 0; ack_cyc.delete();
      do step();
      while (((exp_wr.size() + exp_rd.size() + exp_ack.size()) != 0 || stall) && cyc < max_cyc);
      chk("drained", exp_wr.size() + exp_rd.size() + exp_ack.size(), 0);
      chk("idle_end", stall, 1'b0);
      exc_valid = 1'b0; irq_pending = 1'b0; mret_valid = 1'b0;
      exp_wr.delete(); exp_rd.delete(); exp_ack.delete();
   endtask

   initial begin
      rst = 1'b0; csr_ready = 1'b1;
      exc_valid = 0; irq_pending = 0; mret_valid = 0;
      exc_cause = '0; irq_cause = '0; exc_pc = '0; exc_tval = '0; irq_pc = '0;
      mtvec = '0; mepc = '0; mstatus = '0;
      ready_mode = 0; cyc = 0; first_redir = -1; en_cnt = 0;
      #12;
      chk("rst_we", csr_we, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_exc_en", exc_en, 1'b0);
      chk("rst_redir", {redirect_valid, flush, redirect_pc}, 0);
      chk("rst_acks", {exc_ack, irq_ack, mret_ack}, 3'b000);
      rst = 1'b1;

      // exception, direct mtvec
      exc_cause = 4'd11; exc_pc = 32'h100; exc_tval = 32'h0; mtvec = 32'h200; mstatus = 32'h8;
      round(1, 0, 0, 0, 100);
      chk("t1_latency", first_redir, 5);
      chk("t1_exc_en", en_cnt, 5);

      // vectored interrupt
      irq_cause = 4'd7; irq_pc = 32'h44; mtvec = 32'h201; mstatus = 32'h8;
      round(0, 1, 0, 0, 100);
      chk("t2_latency", first_redir, 5);

      // masked interrupt must be ignored
      mstatus = 32'h0; irq_pending = 1'b1; cyc = 0;
      for (int n = 0; n < 20; n++) begin
         step();
         chk("t3_stall", stall, 1'b0);
         chk("t3_we", csr_we, 1'b0);
         chk("t3_ack", irq_ack, 1'b0);
      end
      irq_pending = 1'b0;

      // mret
      mstatus = 32'h1880; mepc = 32'h104;
      round(0, 0, 1, 0, 100);
      chk("t4_latency", first_redir, 2);
      chk("t4_exc_en", en_cnt, 0);

      // all three together: exc, then irq, then mret, back to back
      exc_cause = 4'd2; exc_pc = 32'h300; exc_tval = 32'hdead; irq_cause = 4'd3; irq_pc = 32'h304;
      mtvec = 32'h1001; mstatus = 32'h8; mepc = 32'h500;
      round(1, 1, 1, 0, 100);
      chk("t5_acks", ack_cyc.size(), 3);
      if (ack_cyc.size() == 3) begin
         chk("t5_irq_cap", ack_cyc[1], 7);
         chk("t5_mret_cap", ack_cyc[2], 13);
      end
      chk("t5_exc_en", en_cnt, 10);

      // csr_ready held low three cycles in W_CAUSE
      exc_cause = 4'd5; exc_pc = 32'h80; exc_tval = 32'h1234; mtvec = 32'h400; mstatus = 32'h0;
      round(1, 0, 0, 2, 100);
      chk("t6_latency", first_redir, 8);
      chk("t6_exc_en", en_cnt, 8);

      // reset in W_TVAL
      ready_mode = 0; cyc = 0; first_redir = -1; ack_cyc.delete();
      model_push(3'b100);
      exc_valid = 1'b1;
      repeat (3) step();
      rst = 1'b0; #1;
      chk("mid_rst_we", {csr_we, csr_addr, csr_wdata}, 0);
      chk("mid_rst_stall", stall, 1'b0);
      chk("mid_rst_exc_en", exc_en, 1'b0);
      chk("mid_rst_redir", {redirect_valid, flush}, 2'b00);
      #2 rst = 1'b1;
      exc_valid = 1'b0;
      exp_wr.delete(); exp_rd.delete(); exp_ack.delete();
      step();
      chk("post_rst_stall", stall, 1'b0);
      chk("post_rst_we", csr_we, 1'b0);

      // randomized request mixes with random CSR back-pressure
      for (int r = 0; r < 40; r++) begin
         exc_cause = 4'($urandom_range(0, 15)); irq_cause = 4'($urandom_range(0, 15));
         exc_pc = $urandom; exc_tval = $urandom; irq_pc = $urandom;
         mtvec = $urandom; mepc = $urandom; mstatus = $urandom;
         round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 300);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
